// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences one load or store at a time between the CPU load/store
// path and a word-addressed RAM. Each request passes through
// SETUP -> ACCESS -> RECOVER, so the RAM strobes are never high together
// and the shared data bus is stable around mem_write.
//
// Ports:
//   clk        sole clock, rising edge
//   clr        synchronous active-high reset
//   req        start request (sampled only in IDLE)
//   we         1 = store, 0 = load (sampled with req)
//   addr_in    request word address (sampled with req)
//   wdata      store data (sampled with req)
//   rdata      last successfully loaded word
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse (RECOVER)
//   err        one-cycle pulse with done for an out-of-range address
//   mem_read   RAM read strobe
//   mem_write  RAM write strobe
//   mem_addr   RAM address (latched request address)
//   mem_data   shared tri-state RAM data bus
//   dbg_state  current FSM state, for checkers
//
// Handshake: req is a level sampled on a rising edge only while busy is low;
// a sampled request is answered by exactly one done pulse N+2 cycles later
// (2 cycles for an out-of-range address). req while busy is dropped, not
// queued, and there is no valid/ready back-pressure beyond busy.
module mem_ctrl #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 256,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic [1:0]        dbg_state
);

  // ACCESS_CYCLES = 1 still needs a 1-bit counter that simply holds 0.
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  // One extra bit so DEPTH = 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_ACCESS  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                out_of_range;
  logic                drive_bus;

  assign out_of_range = ({1'b0, addr_q} >= DEPTH_L);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr_in;
          wdata_d = wdata;
          err_d   = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // Range check happens here so a bad address never reaches ACCESS.
        if (out_of_range) begin
          err_d   = 1'b1;
          state_d = S_RECOVER;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_RECOVER;
          // Capture on the edge that ends the read strobe.
          if (!we_q) rdata_d = mem_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RECOVER: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode registered state only; no input-to-output paths.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RECOVER);
  assign err       = (state_q == S_RECOVER) && err_q;
  assign mem_read  = (state_q == S_ACCESS) && !we_q;
  assign mem_write = (state_q == S_ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

  // Store data is driven from SETUP through RECOVER so it brackets mem_write.
  assign drive_bus = we_q && (state_q != S_IDLE);
  assign mem_data  = drive_bus ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Sequencing memory controller between the CPU datapath's load/store path (MAR/MDR side) and the word-addressed RAM. It accepts one load or store request at a time and drives the RAM's `read`/`write` strobes, 9-bit address and shared tri-state 32-bit data bus through a setup/access/recover sequence, so the two strobes are never high together. Load data is captured into a holding register, and completion is signalled with a one-cycle `done` pulse. Out-of-range addresses are rejected without touching the RAM.

## Interface
- `ADDR_W`, 9: width of request and RAM address.
- `DATA_W`, 32: data word width.
- `DEPTH`, 256: number of implemented RAM words. Valid addresses are 0..DEPTH-1.
- `ACCESS_CYCLES`, 1: cycles a strobe is held asserted. Legal values are at least 1.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `req`  in  1  start request; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `addr_in`  in  ADDR_W  request word address; sampled with `req`.
- `wdata`  in  DATA_W  store data; sampled with `req`.
- `rdata`  out  DATA_W  last successfully loaded word.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, for an out-of-range address.
- `mem_read`  out  1  RAM read strobe.
- `mem_write`  out  1  RAM write strobe.
- `mem_addr`  out  ADDR_W  RAM address; holds the latched address.
- `mem_data`  inout  DATA_W  shared RAM data bus.

## Operation
- **Reset values:** state IDLE; `rdata` = 0; `busy`, `done`, `err`, `mem_read`, `mem_write` = 0; `mem_addr` = 0; `mem_data` = Z.
- **States:** IDLE, SETUP, ACCESS, RECOVER.
- **IDLE to SETUP:** when `req` = 1, latch `we`, `addr_in` and `wdata`, and go to SETUP.
- **SETUP:** `mem_addr` is valid and both strobes are low. If the latched address is at least DEPTH, go to RECOVER with an error flag. Otherwise load the access counter with ACCESS_CYCLES-1 and go to ACCESS.
- **ACCESS:** `mem_read` = !we or `mem_write` = we, held for exactly ACCESS_CYCLES cycles. The counter decrements each cycle; at 0, go to RECOVER.
- **Load capture:** on the edge that leaves ACCESS, `rdata` captures `mem_data`.
- **RECOVER:** both strobes low; `done` = 1, and `err` = 1 if the error flag is set. Next state is IDLE.
- **Bus drive:** for a store, `mem_data` is driven with the latched `wdata` in SETUP, ACCESS and RECOVER, so data is stable before and after `mem_write`. For a load, and in IDLE, `mem_data` is Z.
- **Error path:** an out-of-range request never asserts either strobe and leaves `rdata` unchanged.
- **Requests while busy:** `req` is ignored outside IDLE and is not queued. Input changes after the request is sampled have no effect.
- **Strobe exclusivity:** `mem_read` && `mem_write` is never 1.
- **Reset mid-operation:** `clr` in any state forces the reset values on the next edge. The aborted request produces no `done`. A store interrupted in ACCESS may leave the RAM word written.
- **Back-to-back requests:** `req` sampled in the IDLE cycle that follows RECOVER starts a new transaction. There is no bypass from RECOVER.

## Timing
- Request sampled at edge 0, with N = ACCESS_CYCLES:
  - SETUP in cycle 1.
  - ACCESS in cycles 2..N+1.
  - RECOVER in cycle N+2, with `done` high.
  - IDLE in cycle N+3.
- Out-of-range request: SETUP in cycle 1, RECOVER in cycle 2 with `done` = `err` = 1.
- `rdata` is valid in the RECOVER cycle and holds until the next successful load or `clr`.
- All outputs are registered state decodes; there are no combinational paths from request inputs to outputs.
- Minimum request spacing: N+3 cycles for a valid request, 3 cycles for an out-of-range request.

## Test plan
- **Load, N=1:** RAM[85] = 0x00000002; `req`, `we`=0, `addr_in`=85 at edge 0 → `mem_read` high in cycle 2 only, `done` in cycle 3, `rdata` = 0x00000002, `mem_data` never driven by `mem_ctrl`.
- **Store then load, N=3:** store 0xDEADBEEF to address 10, then load address 10.
  - `mem_write` is high in cycles 2–4.
  - `mem_data` = 0xDEADBEEF in cycles 1–5.
  - `done` pulses in cycle 5.
  - The following load returns `rdata` = 0xDEADBEEF.
- **Out-of-range:** `addr_in` = 0x100 → `done` and `err` in cycle 2, no strobe at any point, `rdata` unchanged.
- **Request while busy:** `req` pulsed again in cycles 1–2 with a different address → ignored; exactly one `done`; `mem_addr` stays at the first address.
- **Reset in ACCESS:** `clr` asserted during an ACCESS cycle (N=3) → next cycle all outputs at reset values, `mem_data` = Z, no `done` pulse.
- **Exclusivity assertion:** across 200 random load/store requests, `mem_read` && `mem_write` is never 1, and every valid request produces exactly one `done`.
